// File: rtl/esm_config_unit.sv
// ESM receiver AXI-Stream configuration slave: parses magic/seq/header/payload messages,
// drives the common enables and forwards other modules' payload. Optional: ESM_CONFIG_SEQ_CHECK_EN.
package esm_config_pkg;
    typedef struct packed {
        logic        valid;
        logic        first;
        logic        last;
        logic [7:0]  module_id;
        logic [7:0]  message_type;
        logic [31:0] data;
    } module_config_t;
endpackage

module esm_config_unit
    import esm_config_pkg::*;
#(
    parameter int          AXI_DATA_WIDTH   = 32,
    parameter logic [31:0] MAGIC_NUM        = 32'h45534D43,
    parameter logic [7:0]  MODULE_ID_COMMON = 8'h00,
    parameter logic [7:0]  MSG_TYPE_ENABLE  = 8'h00
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    output logic                      Axis_ready,
    input  logic                      Axis_valid,
    input  logic                      Axis_last,
    input  logic [AXI_DATA_WIDTH-1:0] Axis_data,
    output logic                      Rst_out,
    output logic [1:0]                Enable_chan,
    output logic [1:0]                Enable_pdw,
    output module_config_t            Module_config
);

    if (AXI_DATA_WIDTH != 32) begin : g_width_check
        $error("esm_config_unit: only AXI_DATA_WIDTH=32 is supported");
    end

    typedef enum logic [2:0] {S_MAGIC, S_SEQ, S_HDR, S_PAYLOAD, S_DROP} state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic        seq_ok;
    logic        first_pl;
    logic [7:0]  mod_id;
    logic [7:0]  msg_type;
    logic [31:0] seq_q;

    assign accept = Axis_valid && Axis_ready;

`ifdef ESM_CONFIG_SEQ_CHECK_EN
    logic        seq_seen;
    logic [31:0] seq_exp;
    logic [31:0] err_cnt;

    // The first message after reset seeds the expected sequence number.
    assign seq_ok = !seq_seen || (Axis_data == seq_exp);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            seq_seen <= 1'b0;
            seq_exp  <= '0;
            err_cnt  <= '0;
        end else if (accept && state == S_SEQ) begin
            if (seq_ok) begin
                seq_seen <= 1'b1;
                seq_exp  <= Axis_data + 32'd1;
            end else begin
                err_cnt <= err_cnt + 32'd1;
            end
        end
    end
`else
    assign seq_ok = 1'b1;
`endif

    always_ff @(posedge Clk) begin
        if (!Rst_n) state <= S_MAGIC;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (state)
                S_MAGIC:   state_nxt = (Axis_data == MAGIC_NUM) ? S_SEQ : S_DROP;
                S_SEQ:     state_nxt = seq_ok ? S_HDR : S_DROP;
                S_HDR:     state_nxt = S_PAYLOAD;
                S_PAYLOAD: state_nxt = S_PAYLOAD;
                S_DROP:    state_nxt = S_DROP;
                default:   state_nxt = S_MAGIC;
            endcase
            if (Axis_last) state_nxt = S_MAGIC;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Axis_ready    <= 1'b0;
            Rst_out       <= 1'b1;
            Enable_chan   <= '0;
            Enable_pdw    <= '0;
            Module_config <= '0;
            first_pl      <= 1'b0;
            mod_id        <= '0;
            msg_type      <= '0;
            seq_q         <= '0;
        end else begin
            Axis_ready          <= 1'b1;
            Module_config.valid <= 1'b0;
            Module_config.first <= 1'b0;
            Module_config.last  <= 1'b0;
            if (accept) begin
                case (state)
                    S_SEQ: seq_q <= Axis_data;
                    S_HDR: begin
                        mod_id   <= Axis_data[31:24];
                        msg_type <= Axis_data[23:16];
                        first_pl <= 1'b1;
                    end
                    S_PAYLOAD: begin
                        first_pl <= 1'b0;
                        if (mod_id == MODULE_ID_COMMON) begin
                            // Only word3 of an enable message matters; the rest is ignored.
                            if (msg_type == MSG_TYPE_ENABLE && first_pl) begin
                                Rst_out     <= Axis_data[0];
                                Enable_chan <= Axis_data[9:8];
                                Enable_pdw  <= Axis_data[17:16];
                            end
                        end else begin
                            Module_config.valid        <= 1'b1;
                            Module_config.first        <= first_pl;
                            Module_config.last         <= Axis_last;
                            Module_config.module_id    <= mod_id;
                            Module_config.message_type <= msg_type;
                            Module_config.data         <= Axis_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_esm_config_unit.sv
// Scoreboard bench for esm_config_unit: a message-level model predicts forwarded
// words (with arrival cycle) and common-module enables.
module tb_esm_config_unit;
    import esm_config_pkg::*;

    localparam logic [31:0] MAGIC = 32'h45534D43;

    typedef struct {
        int             cyc;
        module_config_t mc;
    } sb_t;

    logic           Clk = 1'b0;
    logic           Rst_n;
    logic           Axis_ready;
    logic           Axis_valid;
    logic           Axis_last;
    logic [31:0]    Axis_data;
    logic           Rst_out;
    logic [1:0]     Enable_chan;
    logic [1:0]     Enable_pdw;
    module_config_t Module_config;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    sb_t         sb[$];
    logic [31:0] msg[$];
    logic        exp_rst;
    logic [1:0]  exp_chan, exp_pdw;

    esm_config_unit dut (
        .Clk(Clk), .Rst_n(Rst_n), .Axis_ready(Axis_ready), .Axis_valid(Axis_valid),
        .Axis_last(Axis_last), .Axis_data(Axis_data), .Rst_out(Rst_out),
        .Enable_chan(Enable_chan), .Enable_pdw(Enable_pdw), .Module_config(Module_config)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (Module_config.valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("mc_spurious", 64'(Module_config), 64'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("mc_word", 64'(Module_config), 64'(e.mc));
                chk("mc_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Drives msg[] back to back; the model predicts what each beat should cause.
    task automatic send_msg(input bit term);
        int          n;
        bit          good;
        logic [31:0] hdr;
        logic [31:0] w;
        module_config_t m;
        n    = msg.size();
        good = (n >= 4) && (msg[0] == MAGIC);
        hdr  = (n >= 3) ? msg[2] : 32'd0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            w          = msg[i];
            Axis_valid = 1'b1;
            Axis_data  = w;
            Axis_last  = term && (i == n - 1);
            if (good && i >= 3) begin
                if (hdr[31:24] == 8'h00) begin
                    if (hdr[23:16] == 8'h00 && i == 3) begin
                        exp_rst  = w[0];
                        exp_chan = w[9:8];
                        exp_pdw  = w[17:16];
                    end
                end else begin
                    m.valid        = 1'b1;
                    m.first        = (i == 3);
                    m.last         = Axis_last;
                    m.module_id    = hdr[31:24];
                    m.message_type = hdr[23:16];
                    m.data         = w;
                    sb.push_back('{cyc: cyc + 1, mc: m});
                end
            end
        end
    endtask

    task automatic idle();
        @(negedge Clk);
        Axis_valid = 1'b0;
        Axis_last  = 1'b0;
    endtask

    task automatic check_ctrl(input string tag);
        chk({tag, "_rst"}, 64'(Rst_out), 64'(exp_rst));
        chk({tag, "_chan"}, 64'(Enable_chan), 64'(exp_chan));
        chk({tag, "_pdw"}, 64'(Enable_pdw), 64'(exp_pdw));
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst_n      = 1'b0;
        Axis_valid = 1'b0;
        Axis_last  = 1'b0;
        exp_rst    = 1'b1;
        exp_chan   = 2'd0;
        exp_pdw    = 2'd0;
        repeat (2) @(negedge Clk);
        check_ctrl("reset");
        chk("reset_ready", 64'(Axis_ready), 64'd0);
        chk("reset_mc", 64'(Module_config), 64'd0);
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("ready_after_reset", 64'(Axis_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        Rst_n      = 1'b0;
        Axis_valid = 1'b0;
        Axis_last  = 1'b0;
        Axis_data  = '0;
        do_reset();

        // Common enable message.
        msg = '{MAGIC, 32'd0, 32'h0000_0000, 32'h0003_0300};
        send_msg(1'b1);
        idle();
        check_ctrl("enable");
        chk("enable_vals", {Rst_out, Enable_chan, Enable_pdw}, {1'b0, 2'b11, 2'b11});

        // Dwell entry: six forwarded words.
        msg = '{MAGIC, 32'd1, 32'h0100_0000, 32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
        send_msg(1'b1);
        idle();

        // Bad magic followed directly by a good message from another module.
        msg = '{32'hDEAD_BEEF, 32'd2, 32'h0100_0000, 32'hA1, 32'hA2};
        send_msg(1'b1);
        msg = '{MAGIC, 32'd3, 32'h0205_ABCD, 32'hCAFE_0001, 32'hCAFE_0002};
        send_msg(1'b1);
        idle();
        check_ctrl("bad_magic");

        // Truncated message, then a full one.
        msg = '{MAGIC, 32'd2};
        send_msg(1'b1);
        msg = '{MAGIC, 32'd4, 32'h07FF_0000, 32'h1234_5678};
        send_msg(1'b1);
        idle();

        // Truncated right after the header: no payload, no side effects.
        msg = '{MAGIC, 32'd5, 32'h0000_0000};
        send_msg(1'b1);
        idle();
        check_ctrl("trunc_hdr");

        // Common module, other type: ignored. Enable with extra words: only word3 counts.
        msg = '{MAGIC, 32'd6, 32'h0001_0000, 32'h0000_0001};
        send_msg(1'b1);
        msg = '{MAGIC, 32'd7, 32'h0000_0000, 32'h0001_0201, 32'hFFFF_FFFF};
        send_msg(1'b1);
        idle();
        check_ctrl("enable2");

        // Reset mid-payload, then a fresh message.
        msg = '{MAGIC, 32'd8, 32'h0300_0000, 32'hBEEF_0001, 32'hBEEF_0002};
        send_msg(1'b0);
        do_reset();
        msg = '{MAGIC, 32'd9, 32'h0409_0000, 32'h0F0F_0F0F, 32'hF0F0_F0F0};
        send_msg(1'b1);
        idle();
        check_ctrl("after_reset");

        repeat (3) @(negedge Clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
